async_fifo: RTL and testbench

ASYNC_FIFO -- requirements
Module: async_fifo

---
 rtl/async_fifo_pkg.sv | 34 +++
 rtl/fifo_mem.sv | 39 +++
 rtl/async_fifo.sv | 97 +++++++++
 tb/tb_async_fifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared constants and pointer-compare helpers for the async_fifo block.
//   DATA_WIDTH : default stored word width (bits)
//   ADDR_WIDTH : default address width; depth = 2**ADDR_WIDTH
//   ptr_empty  : pointers identical (wrap bit included)
//   ptr_full   : wrap bits differ, address bits equal
// Pointers are passed zero-extended to 32 bits together with the address
// width, so one pair of helpers serves every parameterisation.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 4;

    // Only the low aw+1 bits of each pointer are significant.
    function automatic logic ptr_empty(input logic [31:0] wr_ptr,
                                       input logic [31:0] rd_ptr,
                                       input int unsigned aw);
        logic [31:0] span;
        span = (32'd1 << (aw + 1)) - 32'd1;
        return ((wr_ptr ^ rd_ptr) & span) == '0;
    endfunction

    // Full when the XOR of the pointers is exactly the wrap bit.
    function automatic logic ptr_full(input logic [31:0] wr_ptr,
                                      input logic [31:0] rd_ptr,
                                      input int unsigned aw);
        logic [31:0] span;
        span = (32'd1 << (aw + 1)) - 32'd1;
        return ((wr_ptr ^ rd_ptr) & span) == (32'd1 << aw);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Storage array for async_fifo: 2**addr_width words of data_width bits.
// Synchronous write port, asynchronous (combinational) read port; the parent
// registers the read data. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
// -----------------------------------------------------------------------------
module fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH,
    parameter int unsigned addr_width = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    localparam int unsigned depth = 1 << addr_width;

    logic [data_width-1:0] mem [0:depth-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/async_fifo.sv
// -----------------------------------------------------------------------------
// async_fifo
// Single-clock FIFO of 2**addr_width words with a registered read port.
// Binary pointers carry one extra wrap bit; full/empty are decoded
// combinationally from the registered pointers.
//   clk      : clock, all state on rising edge
//   rst      : asynchronous active-low reset (clears pointers and data_out)
//   data_in  : write data
//   wr_en    : write request, accepted when not full
//   full     : FIFO holds 2**addr_width words
//   data_out : registered read data, holds when no read is accepted
//   rd_en    : read request, accepted when not empty
//   empty    : FIFO holds no words
// Optional (macro ASYNC_FIFO_ERR_FLAGS_EN defined):
//   overflow  : sticky, set by a write attempt while full
//   underflow : sticky, set by a read attempt while empty
// -----------------------------------------------------------------------------
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH,
    parameter int unsigned addr_width = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] data_in,
    input  logic                  wr_en,
    output logic                  full,
    output logic [data_width-1:0] data_out,
    input  logic                  rd_en,
    output logic                  empty
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    logic [addr_width:0]   wr_ptr;
    logic [addr_width:0]   rd_ptr;
    logic [data_width-1:0] rd_data;
    logic                  wr_ok;
    logic                  rd_ok;

    assign empty = ptr_empty(32'(wr_ptr), 32'(rd_ptr), addr_width);
    assign full  = ptr_full(32'(wr_ptr), 32'(rd_ptr), addr_width);

    // Acceptance uses the flags of the current pointers, so a blocked
    // request stays blocked even if the opposite side moves this cycle.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    fifo_mem #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr[addr_width-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[addr_width-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= rd_data;
            end
        end
    end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo.sv
module tb_async_fifo;

    localparam int unsigned DEPTH = 16;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       wr_en;
    logic       full;
    logic [7:0] data_out;
    logic       rd_en;
    logic       empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    async_fifo #(
        .data_width (8),
        .addr_width (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .full     (full),
        .data_out (data_out),
        .rd_en    (rd_en),
        .empty    (empty)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of held words plus expected registered output
    logic [7:0] q[$];
    logic [7:0] exp_dout;
    bit         exp_ovf;
    bit         exp_unf;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
`endif
    endtask

    // One clock: drive, clock, update model from the pre-edge occupancy, check.
    task automatic cycle(input string tag, input bit w, input bit r, input logic [7:0] d);
        bit wr_acc;
        bit rd_acc;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_acc = w && (q.size() < DEPTH);
        rd_acc = r && (q.size() > 0);
        if (w && q.size() == DEPTH) exp_ovf = 1'b1;
        if (r && q.size() == 0) exp_unf = 1'b1;
        if (rd_acc) exp_dout = q.pop_front();
        if (wr_acc) q.push_back(d);
        check_all(tag);
    endtask

    task automatic do_reset(input int unsigned cycles);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        // Asynchronous clear is visible before any clock edge
        check_all("rst_async");
        repeat (cycles) @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] words [20];
        logic [7:0] held;

        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;

        // Reset
        do_reset(4);

        // Write 8 random, idle 10, read 8
        for (int i = 0; i < 8; i++) cycle("wr8", 1'b1, 1'b0, 8'($urandom));
        repeat (10) cycle("idle", 1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 8; i++) cycle("rd8", 1'b0, 1'b1, 8'($urandom));
        check("rd8_empty_end", 32'(empty), 32'd1);

        // Overflow: 20 writes from empty, words 17-20 dropped
        for (int i = 0; i < 20; i++) begin
            words[i] = 8'($urandom);
            cycle("ovf_wr", 1'b1, 1'b0, words[i]);
            if (i == 15) check("ovf_full_at16", 32'(full), 32'd1);
        end
        for (int i = 0; i < 16; i++) cycle("ovf_rd", 1'b0, 1'b1, 8'($urandom));
        check("ovf_last_word16", 32'(data_out), 32'(words[15]));
        check("ovf_drained", 32'(empty), 32'd1);

        // Underflow: 8 reads while empty
        held = data_out;
        for (int i = 0; i < 8; i++) cycle("unf_rd", 1'b0, 1'b1, 8'($urandom));
        check("unf_dout_held", 32'(data_out), 32'(held));
        // Pointers unchanged: one write/read round-trips the same word
        cycle("unf_probe_wr", 1'b1, 1'b0, 8'h5A);
        cycle("unf_probe_rd", 1'b0, 1'b1, 8'h00);
        check("unf_probe_val", 32'(data_out), 32'h5A);

        // Wrap-around: 48 alternate write/read
        for (int i = 0; i < 48; i++) begin
            cycle("wrap_wr", 1'b1, 1'b0, 8'($urandom));
            check("wrap_not_full", 32'(full), 32'd0);
            cycle("wrap_rd", 1'b0, 1'b1, 8'($urandom));
        end

        // Simultaneous on full: read done, write dropped
        for (int i = 0; i < 16; i++) cycle("sim_fill", 1'b1, 1'b0, 8'($urandom));
        cycle("sim_full_rw", 1'b1, 1'b1, 8'hEE);
        check("sim_full_occ15", 32'(q.size()), 32'd15);
        check("sim_full_notfull", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) cycle("sim_drain", 1'b0, 1'b1, 8'($urandom));

        // Simultaneous on empty: write done, read dropped
        held = data_out;
        cycle("sim_empty_rw", 1'b1, 1'b1, 8'hC3);
        check("sim_empty_dout_held", 32'(data_out), 32'(held));
        check("sim_empty_notempty", 32'(empty), 32'd0);
        cycle("sim_empty_rd", 1'b0, 1'b1, 8'h00);
        check("sim_empty_val", 32'(data_out), 32'hC3);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Mid-operation reset discards contents
        for (int i = 0; i < 5; i++) cycle("pre_rst_wr", 1'b1, 1'b0, 8'($urandom));
        do_reset(2);
        cycle("post_rst_rd", 1'b0, 1'b1, 8'h00);
        cycle("post_rst_wr", 1'b1, 1'b0, 8'h3C);
        cycle("post_rst_rd2", 1'b0, 1'b1, 8'h00);
        check("post_rst_val", 32'(data_out), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
